// File: rtl/shift_chain_arb.sv
// ============================================================================
// Module   : shift_chain_arb
// Purpose  : Two-requester arbiter/sequencer for an external DEPTH-stage serial
//            DFF chain; optional fixed priority via SHIFT_CHAIN_ARB_PRIO_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module shift_chain_arb #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             ser_d,
  input  logic             ser_q,
  output logic             resp_valid,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_data,
  input  logic             resp_ready,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH + DEPTH);
  localparam logic [CNT_W-1:0] C_LAST  = CNT_W'(WIDTH + DEPTH - 1);
  localparam logic [CNT_W-1:0] C_WIDTH = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

  localparam logic [1:0] C_IDLE = 2'd0;
  localparam logic [1:0] C_RUN  = 2'd1;
  localparam logic [1:0] C_RESP = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] tx_q;
  logic [WIDTH-1:0] rx_q;
  logic             id_q;
  logic             w_gnt_id;
  logic             w_accept;

`ifdef SHIFT_CHAIN_ARB_PRIO_EN
  assign w_gnt_id = ~req0_valid;
`else
  logic ptr_q;

  // With both valid, the requester that did not win last time goes next.
  assign w_gnt_id = (req0_valid & req1_valid) ? ~ptr_q : req1_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b1;
    end else if (w_accept) begin
      ptr_q <= w_gnt_id;
    end
  end
`endif

  assign w_accept = req0_ready | req1_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= C_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      C_IDLE:  if (w_accept) state_d = C_RUN;
      C_RUN:   if (cnt_q == C_LAST) state_d = C_RESP;
      C_RESP:  if (resp_ready) state_d = C_IDLE;
      default: state_d = C_IDLE;
    endcase
  end

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    ser_d      = 1'b0;
    if (state_q == C_IDLE) begin
      req0_ready = req0_valid & ~w_gnt_id;
      req1_ready = req1_valid &  w_gnt_id;
    end
    if ((state_q == C_RUN) && (cnt_q < C_WIDTH)) begin
      ser_d = tx_q[WIDTH-1];
    end
    resp_valid = (state_q == C_RESP);
    busy       = (state_q != C_IDLE);
    resp_id    = id_q;
    resp_data  = rx_q;
  end

  // The first DEPTH chain outputs of a run are stale, so capture starts at cnt=DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      tx_q  <= '0;
      rx_q  <= '0;
      id_q  <= 1'b0;
    end else begin
      case (state_q)
        C_IDLE: begin
          if (w_accept) begin
            tx_q  <= w_gnt_id ? req1_data : req0_data;
            id_q  <= w_gnt_id;
            cnt_q <= '0;
          end
        end
        C_RUN: begin
          tx_q  <= {tx_q[WIDTH-2:0], 1'b0};
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q >= C_DEPTH) begin
            rx_q <= {rx_q[WIDTH-2:0], ser_q};
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_shift_chain_arb.sv
// ============================================================================
// Module   : tb_shift_chain_arb
// Purpose  : Directed self-checking bench for shift_chain_arb with chain models.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_shift_chain_arb;

  logic clk;
  logic rst_n;

  logic        a_req0_valid, a_req1_valid, a_req0_ready, a_req1_ready;
  logic [7:0]  a_req0_data, a_req1_data, a_resp_data;
  logic        a_ser_d, a_ser_q, a_resp_valid, a_resp_id, a_resp_ready, a_busy;
  logic [2:0]  a_chain;

  logic        b_req0_valid, b_req1_valid, b_req0_ready, b_req1_ready;
  logic [15:0] b_req0_data, b_req1_data, b_resp_data;
  logic        b_ser_d, b_ser_q, b_resp_valid, b_resp_id, b_resp_ready, b_busy;
  logic        b_chain;

  int n_cmp;
  int n_err;

  shift_chain_arb #(.WIDTH(8), .DEPTH(3)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(a_req0_valid), .req0_data(a_req0_data), .req0_ready(a_req0_ready),
    .req1_valid(a_req1_valid), .req1_data(a_req1_data), .req1_ready(a_req1_ready),
    .ser_d(a_ser_d), .ser_q(a_ser_q),
    .resp_valid(a_resp_valid), .resp_id(a_resp_id), .resp_data(a_resp_data),
    .resp_ready(a_resp_ready), .busy(a_busy)
  );

  shift_chain_arb #(.WIDTH(16), .DEPTH(1)) u_dut16 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(b_req0_valid), .req0_data(b_req0_data), .req0_ready(b_req0_ready),
    .req1_valid(b_req1_valid), .req1_data(b_req1_data), .req1_ready(b_req1_ready),
    .ser_d(b_ser_d), .ser_q(b_ser_q),
    .resp_valid(b_resp_valid), .resp_id(b_resp_id), .resp_data(b_resp_data),
    .resp_ready(b_resp_ready), .busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External chains: plain flops, no reset, no enable.
  always @(posedge clk) a_chain <= {a_chain[1:0], a_ser_d};
  assign a_ser_q = a_chain[2];
  always @(posedge clk) b_chain <= b_ser_d;
  assign b_ser_q = b_chain;

  // Call right after an accept edge; cyc = cycle index at which resp_valid is seen, -1 on timeout.
  task automatic wait_resp(input bit sel, output int cyc);
    cyc = -1;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if ((sel ? b_resp_valid : a_resp_valid) === 1'b1) begin
        cyc = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({a_req0_ready, a_req1_ready, a_ser_d, a_resp_valid, a_resp_id, a_busy} !== 6'b0) begin
      $display("FAIL reset_ctrl: got %b expected 000000",
               {a_req0_ready, a_req1_ready, a_ser_d, a_resp_valid, a_resp_id, a_busy});
      n_err++;
    end
    n_cmp++;
    if (a_resp_data !== 8'h00) begin
      $display("FAIL reset_data: got %h expected 00", a_resp_data);
      n_err++;
    end
    n_cmp++;
    if ({b_resp_valid, b_busy, b_ser_d} !== 3'b0) begin
      $display("FAIL reset_dut16: got %b expected 000", {b_resp_valid, b_busy, b_ser_d});
      n_err++;
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    logic [7:0] exp_w;
    logic       exp_s;
    exp_w = 8'hA5;
    @(negedge clk);
    a_req0_data = exp_w; a_req0_valid = 1'b1; a_resp_ready = 1'b1;
    #1;
    n_cmp++;
    if ({a_req0_ready, a_req1_ready} !== 2'b10) begin
      $display("FAIL single_grant: got %b expected 10", {a_req0_ready, a_req1_ready});
      n_err++;
    end
    @(posedge clk);
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      if (k == 0) begin
        n_cmp++;
        if (a_req0_ready !== 1'b0) begin
          $display("FAIL single_ready_pulse: got %b expected 0", a_req0_ready);
          n_err++;
        end
        a_req0_valid = 1'b0;
      end
      exp_s = (k < 8) ? exp_w[7-k] : 1'b0;
      n_cmp++;
      if (a_ser_d !== exp_s) begin
        $display("FAIL single_ser_d[%0d]: got %b expected %b", k, a_ser_d, exp_s);
        n_err++;
      end
      n_cmp++;
      if (a_resp_valid !== 1'b0) begin
        $display("FAIL single_early_resp[%0d]: got %b expected 0", k, a_resp_valid);
        n_err++;
      end
    end
    @(negedge clk);
    n_cmp++;
    if ({a_resp_valid, a_resp_id, a_resp_data} !== {1'b1, 1'b0, 8'hA5}) begin
      $display("FAIL single_resp: got v=%b id=%b d=%h expected v=1 id=0 d=a5",
               a_resp_valid, a_resp_id, a_resp_data);
      n_err++;
    end
    @(negedge clk);
    n_cmp++;
    if ({a_busy, a_resp_valid} !== 2'b00) begin
      $display("FAIL single_idle: got busy/valid %b expected 00", {a_busy, a_resp_valid});
      n_err++;
    end
  endtask

  task automatic test_contention();
    int         cyc;
    logic       exp_id;
    logic [7:0] exp_d;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    a_req0_data = 8'h3C; a_req1_data = 8'hC3;
    a_req0_valid = 1'b1; a_req1_valid = 1'b1; a_resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
`ifdef SHIFT_CHAIN_ARB_PRIO_EN
      exp_id = 1'b0;
`else
      exp_id = i[0];
`endif
      exp_d = exp_id ? 8'hC3 : 8'h3C;
      n_cmp++;
      if ({a_req1_ready, a_req0_ready} !== {exp_id, ~exp_id}) begin
        $display("FAIL contention_grant[%0d]: got r1r0=%b expected %b",
                 i, {a_req1_ready, a_req0_ready}, {exp_id, ~exp_id});
        n_err++;
      end
      @(posedge clk);
      wait_resp(1'b0, cyc);
      n_cmp++;
      if (cyc !== 11) begin
        $display("FAIL contention_latency[%0d]: got %0d expected 11", i, cyc);
        n_err++;
      end
      n_cmp++;
      if ({a_resp_id, a_resp_data, a_req0_ready, a_req1_ready} !== {exp_id, exp_d, 2'b00}) begin
        $display("FAIL contention_resp[%0d]: got id=%b d=%h rdy=%b expected id=%b d=%h rdy=00",
                 i, a_resp_id, a_resp_data, {a_req0_ready, a_req1_ready}, exp_id, exp_d);
        n_err++;
      end
      @(negedge clk);
    end
    a_req0_valid = 1'b0; a_req1_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    int   cyc;
    logic exp_r1;
    a_req0_data = 8'h5A; a_req0_valid = 1'b1; a_resp_ready = 1'b0;
    @(posedge clk);
    wait_resp(1'b0, cyc);
    n_cmp++;
    if (cyc !== 11) begin
      $display("FAIL bp_latency: got %0d expected 11", cyc);
      n_err++;
    end
    a_req1_valid = 1'b1;
    for (int j = 0; j < 5; j++) begin
      if (j > 0) @(negedge clk);
      #1;
      n_cmp++;
      if ({a_resp_valid, a_resp_id, a_resp_data, a_busy, a_req0_ready, a_req1_ready}
          !== {1'b1, 1'b0, 8'h5A, 1'b1, 2'b00}) begin
        $display("FAIL bp_hold[%0d]: got v=%b id=%b d=%h busy=%b rdy=%b expected v=1 id=0 d=5a busy=1 rdy=00",
                 j, a_resp_valid, a_resp_id, a_resp_data, a_busy, {a_req0_ready, a_req1_ready});
        n_err++;
      end
    end
    a_resp_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({a_busy, a_resp_valid} !== 2'b00) begin
      $display("FAIL bp_release: got busy/valid %b expected 00", {a_busy, a_resp_valid});
      n_err++;
    end
`ifdef SHIFT_CHAIN_ARB_PRIO_EN
    exp_r1 = 1'b0;
`else
    exp_r1 = 1'b1;
`endif
    n_cmp++;
    if ({a_req1_ready, a_req0_ready} !== {exp_r1, ~exp_r1}) begin
      $display("FAIL bp_next_grant: got r1r0=%b expected %b",
               {a_req1_ready, a_req0_ready}, {exp_r1, ~exp_r1});
      n_err++;
    end
    a_req0_valid = 1'b0; a_req1_valid = 1'b0;
    #1;
    n_cmp++;
    if ({a_req0_ready, a_req1_ready} !== 2'b00) begin
      $display("FAIL bp_valid_drop: got %b expected 00", {a_req0_ready, a_req1_ready});
      n_err++;
    end
    @(negedge clk);
    n_cmp++;
    if (a_busy !== 1'b0) begin
      $display("FAIL bp_no_accept: got busy %b expected 0", a_busy);
      n_err++;
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    a_req0_data = 8'h96; a_req0_valid = 1'b1; a_resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_req0_valid = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++;
    if (a_busy !== 1'b1) begin
      $display("FAIL rstmid_busy: got %b expected 1", a_busy);
      n_err++;
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({a_req0_ready, a_req1_ready, a_ser_d, a_resp_valid, a_resp_id, a_busy, a_resp_data}
        !== 14'b0) begin
      $display("FAIL rstmid_async: got ctrl=%b d=%h expected ctrl=000000 d=00",
               {a_req0_ready, a_req1_ready, a_ser_d, a_resp_valid, a_resp_id, a_busy}, a_resp_data);
      n_err++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    n_cmp++;
    if ({a_resp_valid, a_busy} !== 2'b00) begin
      $display("FAIL rstmid_dropped: got valid/busy %b expected 00", {a_resp_valid, a_busy});
      n_err++;
    end
    a_req0_data = 8'hFF; a_req0_valid = 1'b1;
    #1;
    n_cmp++;
    if (a_req0_ready !== 1'b1) begin
      $display("FAIL rstmid_regrant: got %b expected 1", a_req0_ready);
      n_err++;
    end
    @(posedge clk);
    wait_resp(1'b0, cyc);
    a_req0_valid = 1'b0;
    n_cmp++;
    if ({cyc == 11, a_resp_id, a_resp_data} !== {1'b1, 1'b0, 8'hFF}) begin
      $display("FAIL rstmid_resp: got cyc=%0d id=%b d=%h expected cyc=11 id=0 d=ff",
               cyc, a_resp_id, a_resp_data);
      n_err++;
    end
    @(negedge clk);
  endtask

  task automatic test_sweep();
    int cyc;
    b_req0_data = 16'h8001; b_req0_valid = 1'b1; b_resp_ready = 1'b1;
    #1;
    n_cmp++;
    if (b_req0_ready !== 1'b1) begin
      $display("FAIL sweep_grant: got %b expected 1", b_req0_ready);
      n_err++;
    end
    @(posedge clk);
    wait_resp(1'b1, cyc);
    b_req0_valid = 1'b0;
    n_cmp++;
    if (cyc !== 17) begin
      $display("FAIL sweep_latency: got %0d expected 17", cyc);
      n_err++;
    end
    n_cmp++;
    if ({b_resp_id, b_resp_data} !== {1'b0, 16'h8001}) begin
      $display("FAIL sweep_resp: got id=%b d=%h expected id=0 d=8001", b_resp_id, b_resp_data);
      n_err++;
    end
    @(negedge clk);
    n_cmp++;
    if (b_busy !== 1'b0) begin
      $display("FAIL sweep_idle: got busy %b expected 0", b_busy);
      n_err++;
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0;
    a_req0_valid = 1'b0; a_req1_valid = 1'b0; a_req0_data = '0; a_req1_data = '0;
    a_resp_ready = 1'b0;
    b_req0_valid = 1'b0; b_req1_valid = 1'b0; b_req0_data = '0; b_req1_data = '0;
    b_resp_ready = 1'b0;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_reset_mid();
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/shift_chain_arb.md
# shift_chain_arb

Two-requester arbiter and sequencer for the shared serial DFF shift chain. It grants the chain to one requester at a time, serialises that requester's parallel word onto the chain input MSB-first, and captures the word back from the chain output after the chain's fixed depth. It returns the recovered word to the winning requester over a valid/ready response channel. It sits between the parallel-word producers and the external DEPTH-stage chain, whose stages shift on every clk edge and have no enable.

## Interface
- WIDTH, 8: word width in bits, ≥2.
- DEPTH, 3: number of flops in the external chain, ≥1.

- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has a word.
- req0_data  in  WIDTH  requester 0 word.
- req0_ready  out  1  requester 0 word accepted this edge.
- req1_valid, req1_data, req1_ready: same as requester 0, for requester 1.
- ser_d  out  1  drives the chain input.
- ser_q  in  1  chain output.
- resp_valid  out  1  recovered word available.
- resp_id  out  1  requester that owns the response.
- resp_data  out  WIDTH  recovered word.
- resp_ready  in  1  consumer accepts the response.
- busy  out  1  high in any state other than IDLE.

## Operation
- States:
  - IDLE: waiting for a request.
  - RUN: cycle counter cnt runs 0..WIDTH+DEPTH-1.
  - RESP: response held until consumed.
- IDLE:
  - reqN_ready = 1 only for the granted requester, and only when its valid is high. Ready is combinational from state, valids and the arbitration pointer.
  - Accept edge: load tx shift register with the granted data, latch resp_id, clear cnt, go to RUN.
- Arbitration: round-robin.
  - Pointer holds the last-granted id. Reset value 1, so requester 0 wins first.
  - If only one requester is valid, that requester wins.
  - If both are valid, the requester other than the pointer wins.
  - The pointer updates only on an accept edge.
- RUN:
  - ser_d = tx[WIDTH-1] while cnt < WIDTH; 0 otherwise.
  - tx shifts left each edge.
  - Capture: on edges where cnt ≥ DEPTH, rx <= {rx[WIDTH-2:0], ser_q}.
  - cnt increments each edge. On the edge where cnt = WIDTH+DEPTH-1: final capture, go to RESP.
- RESP:
  - resp_valid = 1. resp_data = rx and resp_id stay stable until the handshake.
  - On an edge with resp_valid & resp_ready, go to IDLE.
  - No new request is accepted in RESP.
- ser_d = 0 in IDLE and RESP.
- Stale chain contents never reach rx: the capture window opens only after DEPTH edges of fresh data.

## Timing
- Reset values: state IDLE, req0_ready=0, req1_ready=0, ser_d=0, resp_valid=0, resp_id=0, resp_data=0, busy=0, pointer=1, cnt=0.
- Accept at edge E0:
  - ser_d carries bit WIDTH-1-k during cycle k after E0, for k = 0..WIDTH-1.
  - resp_valid rises after edge E0+WIDTH+DEPTH. That is 11 cycles for the defaults.
- Minimum request-to-request spacing: WIDTH+DEPTH+2 cycles (RUN, one RESP cycle with resp_ready high, one IDLE cycle).
- resp_ready held low: stay in RESP indefinitely with outputs stable; both reqN_ready stay 0.
- Reset asserted mid-RUN or mid-RESP: immediate return to reset values. The in-flight word is dropped and no response is issued.
- Request valid dropping before ready: no accept, pointer unchanged.

## Configuration
- SHIFT_CHAIN_ARB_PRIO_EN defined: fixed priority. Requester 0 always wins when valid; the pointer is not used.
- Undefined (default): round-robin as described in Operation.

## Test plan
- Single request: req0_data=0xA5 with req0_valid=1, resp_ready=1, default parameters.
  - req0_ready pulses for one cycle.
  - ser_d serial stream is 1,0,1,0,0,1,0,1.
  - resp_valid rises 11 cycles after the accept, with resp_id=0 and resp_data=0xA5.
- Contention: both valid continuously, req0=0x3C, req1=0xC3.
  - Grants go 0,1,0,1.
  - Responses alternate 0x3C/id0 and 0xC3/id1.
- Backpressure: resp_ready held low for 5 cycles after resp_valid rises.
  - resp_valid, resp_data and resp_id stay stable; busy=1; no reqN_ready.
  - Return to IDLE on the edge after resp_ready rises.
- Reset mid-shift: rst_n low at cnt=4.
  - All outputs return to reset values asynchronously.
  - After release, a request with 0xFF returns exactly 0xFF.
- Parameter sweep: DEPTH=1 and WIDTH=16, with 0x8001.
  - Response arrives 17 cycles after accept with the value intact.
- Macro SHIFT_CHAIN_ARB_PRIO_EN defined, both requesters valid for 4 transactions.
  - All 4 grants go to requester 0; req1_ready stays 0.
